// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shifts a command byte on device clocks, checks ACK.
// Optional watchdog compiled in when PS2_TX_TIMEOUT_EN is defined.

module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 2500,
  parameter int unsigned SETUP_CYCLES   = 25,
  parameter int unsigned TIMEOUT_CYCLES = 375000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       done,
  output logic       err,
  output logic       rx_inhibit,
  inout  wire        MOUSE_CLOCK,
  inout  wire        MOUSE_DATA
);

  localparam int unsigned TMR_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] INHIBIT_LOAD = TMR_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETUP_LOAD   = TMR_W'(SETUP_CYCLES - 1);

  if (INHIBIT_CYCLES == 0 || SETUP_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("ps2_host_tx: cycle count parameters must be non-zero");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [3:0]       bit_q, bit_d;
  logic [9:0]       frame_q, frame_d;
  logic             clk_low_q, clk_low_d;
  logic             data_low_q, data_low_d;
  logic             ack_err_q, ack_err_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d, clk_prev_q, clk_prev_d;
  logic             dat_meta_q, dat_meta_d, dat_sync_q, dat_sync_d;
  logic             fall;
  logic             accept;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  assign tx_ready   = (state_q == S_IDLE) && !done_q;
  assign rx_inhibit = (state_q != S_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign accept     = tx_valid && tx_ready;
  assign fall       = clk_prev_q && !clk_sync_q;

  assign MOUSE_CLOCK = clk_low_q  ? 1'b0 : 1'bz;
  assign MOUSE_DATA  = data_low_q ? 1'b0 : 1'bz;

  always_comb begin
    clk_meta_d = MOUSE_CLOCK;
    clk_sync_d = clk_meta_q;
    clk_prev_d = clk_sync_q;
    dat_meta_d = MOUSE_DATA;
    dat_sync_d = dat_meta_q;

    state_d    = state_q;
    tmr_d      = tmr_q;
    bit_d      = bit_q;
    frame_d    = frame_q;
    clk_low_d  = clk_low_q;
    data_low_d = data_low_q;
    ack_err_d  = ack_err_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
        if (accept) begin
          state_d   = S_INHIBIT;
          tmr_d     = INHIBIT_LOAD;
          bit_d     = 4'd0;
          frame_d   = {1'b1, ~^tx_data, tx_data};
          clk_low_d = 1'b1;
          ack_err_d = 1'b0;
        end
      end
      S_INHIBIT: begin
        if (tmr_q == '0) begin
          state_d    = S_REQ;
          tmr_d      = SETUP_LOAD;
          data_low_d = 1'b1;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_REQ: begin
        // Data is already low (start bit); releasing the clock hands timing to the device.
        if (tmr_q == '0) begin
          state_d   = S_SHIFT;
          clk_low_d = 1'b0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_SHIFT: begin
        if (fall) begin
          data_low_d = ~frame_q[bit_q];
          bit_d      = bit_q + 4'd1;
          if (bit_q == 4'd9) state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (fall) begin
          ack_err_d = dat_sync_q;
          state_d   = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_sync_q && dat_sync_q) begin
          done_d  = 1'b1;
          err_d   = ack_err_q;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    wd_d = wd_q;
    if (accept) begin
      wd_d = '0;
    end else if (state_q == S_REQ || state_q == S_SHIFT || state_q == S_ACK || state_q == S_WAIT_IDLE) begin
      if (wd_q == WD_LAST) begin
        state_d    = S_IDLE;
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
        done_d     = 1'b1;
        err_d      = 1'b1;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      bit_q      <= 4'd0;
      frame_q    <= '0;
      clk_low_q  <= 1'b0;
      data_low_q <= 1'b0;
      ack_err_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      bit_q      <= bit_d;
      frame_q    <= frame_d;
      clk_low_q  <= clk_low_d;
      data_low_q <= data_low_d;
      ack_err_q  <= ack_err_d;
      done_q     <= done_d;
      err_q      <= err_d;
      clk_meta_q <= clk_meta_d;
      clk_sync_q <= clk_sync_d;
      clk_prev_q <= clk_prev_d;
      dat_meta_q <= dat_meta_d;
      dat_sync_q <= dat_sync_d;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q       <= wd_d;
`endif
    end
  end

endmodule
